// File: rtl/banco_registros_param.sv
// Parametrised register file with one write port and NUM_LECT registered read ports.
// After reset or a limpiar pulse, a sequential sweep writes zero to every register.
module banco_registros_param #(
    parameter int ANCHO     = 32,
    parameter int NUM_REG   = 32,
    parameter int NUM_LECT  = 2,
    parameter int CERO_FIJO = 1,
    parameter int BYPASS    = 1,
    localparam int DIR_ANCHO = $clog2(NUM_REG)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          limpiar,
    input  logic                          WE,
    input  logic [DIR_ANCHO-1:0]          direccionEscritura,
    input  logic [ANCHO-1:0]              datos,
    input  logic [NUM_LECT*DIR_ANCHO-1:0] direccionesLectura,
    input  logic                          leer,
    output logic [NUM_LECT*ANCHO-1:0]     salidas,
    output logic                          salidaValida,
    output logic                          ocupado
);

    typedef enum logic {LISTO, BORRANDO} estado_t;

    estado_t                   r_estado;
    logic [DIR_ANCHO-1:0]      r_indice;
    logic                      r_ocupado;
    logic                      r_valida;
    logic [NUM_LECT*ANCHO-1:0] r_salidas;
    logic [ANCHO-1:0]          r_mem [NUM_REG];

    logic                      w_escribir;
    logic                      w_leer;
    logic [ANCHO-1:0]          w_lect [NUM_LECT];

    assign w_escribir = (r_estado == LISTO) && WE &&
                        !((CERO_FIJO != 0) && (direccionEscritura == '0));
    assign w_leer     = (r_estado == LISTO) && leer;

    // Zero-register override wins over the bypass so r0 never leaks written data.
    for (genvar k = 0; k < NUM_LECT; k++) begin : g_lect
        logic [DIR_ANCHO-1:0] w_dir;
        assign w_dir = direccionesLectura[k*DIR_ANCHO +: DIR_ANCHO];
        assign w_lect[k] = ((CERO_FIJO != 0) && (w_dir == '0)) ? '0 :
                           ((BYPASS != 0) && WE && (w_dir == direccionEscritura)) ? datos :
                           r_mem[w_dir];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= BORRANDO;
            r_indice  <= '0;
            r_ocupado <= 1'b1;
            r_valida  <= 1'b0;
            r_salidas <= '0;
        end else begin
            case (r_estado)
                LISTO: begin
                    if (limpiar) begin
                        r_estado  <= BORRANDO;
                        r_indice  <= '0;
                        r_ocupado <= 1'b1;
                    end
                end
                BORRANDO: begin
                    if (r_indice == DIR_ANCHO'(NUM_REG - 1)) begin
                        r_estado  <= LISTO;
                        r_ocupado <= 1'b0;
                    end else begin
                        r_indice <= r_indice + DIR_ANCHO'(1);
                    end
                end
                default: begin
                    r_estado  <= BORRANDO;
                    r_indice  <= '0;
                    r_ocupado <= 1'b1;
                end
            endcase

            r_valida <= w_leer;
            if (w_leer) begin
                for (int k = 0; k < NUM_LECT; k++) begin
                    r_salidas[k*ANCHO +: ANCHO] <= w_lect[k];
                end
            end
        end
    end

    // Storage has no reset; while reset is held the FSM sits in BORRANDO at index 0.
    always_ff @(posedge clk) begin
        if (r_estado == BORRANDO) begin
            r_mem[r_indice] <= '0;
        end else if (w_escribir) begin
            r_mem[direccionEscritura] <= datos;
        end
    end

    assign salidas      = r_salidas;
    assign salidaValida = r_valida;
    assign ocupado      = r_ocupado;

endmodule

// File: tb/tb_banco_registros_param.sv
// Directed bench for banco_registros_param: default build, a BYPASS=0 build sharing
// its stimulus, and a 16-bit / 8-register / 4-read-port build.
module tb_banco_registros_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        limpiar;
    logic        WE;
    logic [4:0]  dirEsc;
    logic [31:0] datos;
    logic [9:0]  dirLect;
    logic        leer;
    logic [63:0] sal_a, sal_b;
    logic        val_a, val_b, ocu_a, ocu_b;

    logic        limpiar_c;
    logic        WE_c;
    logic [2:0]  dirEsc_c;
    logic [15:0] datos_c;
    logic [11:0] dirLect_c;
    logic        leer_c;
    logic [63:0] sal_c;
    logic        val_c, ocu_c;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt, cnt_c;

    always #5 clk = ~clk;

    banco_registros_param dut_a (
        .clk(clk), .rst_n(rst_n), .limpiar(limpiar), .WE(WE),
        .direccionEscritura(dirEsc), .datos(datos), .direccionesLectura(dirLect),
        .leer(leer), .salidas(sal_a), .salidaValida(val_a), .ocupado(ocu_a)
    );

    banco_registros_param #(.BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .limpiar(limpiar), .WE(WE),
        .direccionEscritura(dirEsc), .datos(datos), .direccionesLectura(dirLect),
        .leer(leer), .salidas(sal_b), .salidaValida(val_b), .ocupado(ocu_b)
    );

    banco_registros_param #(.ANCHO(16), .NUM_REG(8), .NUM_LECT(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .limpiar(limpiar_c), .WE(WE_c),
        .direccionEscritura(dirEsc_c), .datos(datos_c), .direccionesLectura(dirLect_c),
        .leer(leer_c), .salidas(sal_c), .salidaValida(val_c), .ocupado(ocu_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        WE = 1'b1; dirEsc = a; datos = d;
        step();
        WE = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        leer = 1'b1; dirLect = {a1, a0};
        step();
        leer = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; limpiar = 1'b0; WE = 1'b0; dirEsc = '0; datos = '0;
        dirLect = '0; leer = 1'b0;
        limpiar_c = 1'b0; WE_c = 1'b0; dirEsc_c = '0; datos_c = '0;
        dirLect_c = '0; leer_c = 1'b0;
        step(); step();
        check("reset_salidas", sal_a, 64'd0);
        check("reset_valida", {63'd0, val_a}, 64'd1 - 64'd1);
        check("reset_ocupado", {63'd0, ocu_a}, 64'd1);

        // Initial sweep length for both register counts
        rst_n = 1'b1;
        cnt = 0; cnt_c = 0;
        while (ocu_a && cnt < 100) begin
            step();
            cnt++;
            if (!ocu_c && cnt_c == 0) cnt_c = cnt;
        end
        check("sweep_len_32", 64'(cnt), 64'd32);
        check("sweep_len_8", 64'(cnt_c), 64'd8);

        rd(5'd5, 5'd31);
        check("rd_unwritten_valida", {63'd0, val_a}, 64'd1);
        check("rd_unwritten_data", sal_a, 64'd0);
        step();
        check("valida_drops", {63'd0, val_a}, 64'd0);

        wr(5'd7, 32'hDEADBEEF);
        rd(5'd7, 5'd7);
        check("rd_r7_r7", sal_a, {32'hDEADBEEF, 32'hDEADBEEF});
        step();
        check("salidas_hold", sal_a, {32'hDEADBEEF, 32'hDEADBEEF});

        wr(5'd0, 32'h00001234);
        rd(5'd0, 5'd7);
        check("rd_r0_zero", sal_a, {32'hDEADBEEF, 32'h0});

        // Same-cycle write and read: forwarded on dut_a, old contents on dut_b
        wr(5'd3, 32'h00000055);
        wr(5'd9, 32'h11111111);
        WE = 1'b1; dirEsc = 5'd9; datos = 32'hCAFE0001;
        leer = 1'b1; dirLect = {5'd3, 5'd9};
        step();
        WE = 1'b0; leer = 1'b0;
        check("bypass_on", sal_a, {32'h55, 32'hCAFE0001});
        check("bypass_off", sal_b, {32'h55, 32'h11111111});
        rd(5'd9, 5'd3);
        check("after_write_b", sal_b, {32'h55, 32'hCAFE0001});

        // Narrow four-port build
        for (int i = 1; i < 8; i++) begin
            WE_c = 1'b1; dirEsc_c = 3'(i); datos_c = 16'(16'h1111 * i);
            step();
        end
        WE_c = 1'b0;
        leer_c = 1'b1; dirLect_c = {3'd0, 3'd1, 3'd6, 3'd7};
        step();
        leer_c = 1'b0;
        check("c4_read", sal_c, {16'h0000, 16'h1111, 16'h6666, 16'h7777});
        check("c4_valida", {63'd0, val_c}, 64'd1);

        // Fill, then clear sweep with writes, reads and limpiar ignored meanwhile
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
        rd(5'd31, 5'd17);
        check("filled", sal_a, {32'd17, 32'd31});
        limpiar = 1'b1;
        step();
        limpiar = 1'b0;
        check("clear_ocupado", {63'd0, ocu_a}, 64'd1);
        cnt = 0;
        while (ocu_a && cnt < 100) begin
            WE = 1'b1; dirEsc = 5'd5; datos = 32'hAAAAAAAA;
            leer = 1'b1; dirLect = {5'd5, 5'd31};
            limpiar = (cnt == 20);
            step();
            cnt++;
            check("sweep_no_valida", {63'd0, val_a}, 64'd0);
        end
        WE = 1'b0; leer = 1'b0; limpiar = 1'b0;
        check("clear_len_32", 64'(cnt), 64'd32);
        for (int i = 0; i < 32; i += 2) begin
            rd(5'(i), 5'(i + 1));
            check("cleared_read", sal_a, 64'd0);
        end

        // Reset in mid-sweep restarts the count
        wr(5'd2, 32'hFFFF0000);
        rd(5'd2, 5'd2);
        check("pre_reset_data", sal_a, {32'hFFFF0000, 32'hFFFF0000});
        limpiar = 1'b1;
        step();
        limpiar = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        #1;
        check("async_reset_salidas", sal_a, 64'd0);
        check("async_reset_ocupado", {63'd0, ocu_a}, 64'd1);
        step();
        rst_n = 1'b1;
        cnt = 0;
        while (ocu_a && cnt < 100) begin
            step();
            cnt++;
        end
        check("resweep_len_32", 64'(cnt), 64'd32);
        rd(5'd2, 5'd9);
        check("resweep_cleared", sal_a, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
